// File: rtl/hit_segment_merger.sv
// Pops (s, q, l) seed hits from the hit FIFO and merges same-diagonal hits into segments.
// Optional macro HIT_MIN_LEN_FILTER_EN drops closed segments shorter than MIN_LEN.
module hit_segment_merger #(
    parameter int DW      = 8,
    parameter int SLW     = 10,
    parameter int MAX_GAP = 2,
    parameter int MIN_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fifo_empty,
    output logic           fifo_rd_en,
    input  logic [DW-1:0]  fifo_s,
    input  logic [DW-1:0]  fifo_q,
    input  logic [DW-1:0]  fifo_l,
    input  logic           flush,
    output logic           seg_valid,
    input  logic           seg_ready,
    output logic [DW-1:0]  seg_s,
    output logic [DW-1:0]  seg_q,
    output logic [SLW-1:0] seg_l,
    output logic           flush_done,
    output logic           busy
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REQ        = 3'd1,
        S_CAP        = 3'd2,
        S_EMIT       = 3'd3,
        S_FLUSH_EMIT = 3'd4
    } state_t;

    localparam int              PADW      = SLW + 2 - DW;
    localparam logic [SLW-1:0]  L_MAX     = {SLW{1'b1}};
    localparam logic [SLW-1:0]  MIN_LEN_W = SLW'(MIN_LEN);
    localparam logic [SLW+1:0]  GAP_W     = (SLW+2)'(MAX_GAP);
`ifdef HIT_MIN_LEN_FILTER_EN
    localparam logic            FILTER_EN = 1'b1;
`else
    localparam logic            FILTER_EN = 1'b0;
`endif

    state_t         state_q, state_d;
    logic           open_q, open_d;
    logic [DW-1:0]  cur_s_q, cur_s_d, cur_q_q, cur_q_d;
    logic [SLW-1:0] cur_l_q, cur_l_d;
    logic [DW:0]    cur_diag_q, cur_diag_d;
    logic           rd_en_q, rd_en_d;
    logic           seg_valid_q, seg_valid_d;
    logic [DW-1:0]  seg_s_q, seg_s_d, seg_q_q, seg_q_d;
    logic [SLW-1:0] seg_l_q, seg_l_d;
    logic           flush_done_q, flush_done_d;
    logic           busy_q, busy_d;
    logic           armed_q, armed_d;

    logic [DW:0]    hit_diag;
    logic [SLW+1:0] seg_end, hit_end, new_end, new_len;
    logic           mergeable, keep_cur;

    function automatic logic [SLW-1:0] sat_len(input logic [SLW+1:0] len);
        if (len > {2'b00, L_MAX}) begin
            sat_len = L_MAX;
        end else begin
            sat_len = len[SLW-1:0];
        end
    endfunction

    // Merge datapath: diagonal, segment end and extended length of the captured hit.
    always_comb begin
        hit_diag  = {1'b0, fifo_s} - {1'b0, fifo_q};
        seg_end   = {{PADW{1'b0}}, cur_s_q} + {2'b00, cur_l_q};
        hit_end   = {{PADW{1'b0}}, fifo_s} + {{PADW{1'b0}}, fifo_l};
        new_end   = (hit_end > seg_end) ? hit_end : seg_end;
        new_len   = new_end - {{PADW{1'b0}}, cur_s_q};
        mergeable = (hit_diag == cur_diag_q) && (fifo_s >= cur_s_q) &&
                    ({{PADW{1'b0}}, fifo_s} <= (seg_end + GAP_W));
        keep_cur  = !FILTER_EN || (cur_l_q >= MIN_LEN_W);
    end

    // Next-state and output-register computation.
    always_comb begin
        state_d      = state_q;
        open_d       = open_q;
        cur_s_d      = cur_s_q;
        cur_q_d      = cur_q_q;
        cur_l_d      = cur_l_q;
        cur_diag_d   = cur_diag_q;
        rd_en_d      = 1'b0;
        seg_valid_d  = 1'b0;
        seg_s_d      = seg_s_q;
        seg_q_d      = seg_q_q;
        seg_l_d      = seg_l_q;
        flush_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = S_REQ;
                end else if (flush && armed_q) begin
                    if (open_q && keep_cur) begin
                        seg_s_d     = cur_s_q;
                        seg_q_d     = cur_q_q;
                        seg_l_d     = cur_l_q;
                        seg_valid_d = 1'b1;
                        state_d     = S_FLUSH_EMIT;
                    end else begin
                        open_d       = 1'b0;
                        flush_done_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                state_d = S_IDLE;
                if (fifo_l == {DW{1'b0}}) begin
                    open_d = open_q;
                end else if (open_q && mergeable) begin
                    cur_l_d = sat_len(new_len);
                end else begin
                    // The new hit always becomes the open segment; the old one leaves if it was open.
                    if (open_q && keep_cur) begin
                        seg_s_d     = cur_s_q;
                        seg_q_d     = cur_q_q;
                        seg_l_d     = cur_l_q;
                        seg_valid_d = 1'b1;
                        state_d     = S_EMIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                    open_d     = 1'b1;
                    cur_s_d    = fifo_s;
                    cur_q_d    = fifo_q;
                    cur_l_d    = {{(SLW-DW){1'b0}}, fifo_l};
                    cur_diag_d = hit_diag;
                end
            end
            S_EMIT: begin
                if (seg_ready) begin
                    state_d = S_IDLE;
                end else begin
                    seg_valid_d = 1'b1;
                end
            end
            S_FLUSH_EMIT: begin
                if (seg_ready) begin
                    open_d       = 1'b0;
                    flush_done_d = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    seg_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A flush completes once; a new one needs flush to drop first.
        if (flush_done_d) begin
            armed_d = 1'b0;
        end else if (!flush) begin
            armed_d = 1'b1;
        end else begin
            armed_d = armed_q;
        end
        busy_d = (state_d != S_IDLE) || open_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            open_q       <= 1'b0;
            cur_s_q      <= {DW{1'b0}};
            cur_q_q      <= {DW{1'b0}};
            cur_l_q      <= {SLW{1'b0}};
            cur_diag_q   <= {(DW+1){1'b0}};
            rd_en_q      <= 1'b0;
            seg_valid_q  <= 1'b0;
            seg_s_q      <= {DW{1'b0}};
            seg_q_q      <= {DW{1'b0}};
            seg_l_q      <= {SLW{1'b0}};
            flush_done_q <= 1'b0;
            busy_q       <= 1'b0;
            armed_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            open_q       <= open_d;
            cur_s_q      <= cur_s_d;
            cur_q_q      <= cur_q_d;
            cur_l_q      <= cur_l_d;
            cur_diag_q   <= cur_diag_d;
            rd_en_q      <= rd_en_d;
            seg_valid_q  <= seg_valid_d;
            seg_s_q      <= seg_s_d;
            seg_q_q      <= seg_q_d;
            seg_l_q      <= seg_l_d;
            flush_done_q <= flush_done_d;
            busy_q       <= busy_d;
            armed_q      <= armed_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign seg_valid  = seg_valid_q;
    assign seg_s      = seg_s_q;
    assign seg_q      = seg_q_q;
    assign seg_l      = seg_l_q;
    assign flush_done = flush_done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_hit_segment_merger.sv
// Bench for hit_segment_merger: vector table plus hand-written EMIT stall, reset and flush sequences.
module tb_hit_segment_merger;
    localparam int DW = 8, SLW = 10, MIN_LEN = 4;

    logic           clk = 1'b0;
    logic           rst, fifo_empty, fifo_rd_en, flush, seg_valid, seg_ready, flush_done, busy;
    logic [DW-1:0]  fifo_s = 8'd0, fifo_q = 8'd0, fifo_l = 8'd0, seg_s, seg_q;
    logic [SLW-1:0] seg_l;

    always #5 clk = ~clk;

    hit_segment_merger #(.DW(DW), .SLW(SLW), .MAX_GAP(2), .MIN_LEN(MIN_LEN)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_s(fifo_s), .fifo_q(fifo_q), .fifo_l(fifo_l), .flush(flush),
        .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_s(seg_s), .seg_q(seg_q),
        .seg_l(seg_l), .flush_done(flush_done), .busy(busy)
    );

    // FIFO model with registered read data
    logic [23:0] mem [0:127];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
            {fifo_s, fifo_q, fifo_l} <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] q;
        logic [9:0] l;
    } seg_t;

    typedef struct packed {
        logic [1:0]      nh;
        logic [2:0][7:0] hs, hq, hl;
        logic [1:0]      ns;
        logic [2:0][7:0] es, eq;
        logic [2:0][9:0] el;
    } vec_t;

    seg_t exp_q[$];
    vec_t vecs[15];
    int   n_run = 0, n_fail = 0, fd_cnt = 0, bad_rd = 0;

    function automatic vec_t mkv(input int nh, input int s0, q0, l0, s1, q1, l1, s2, q2, l2,
                                 input int ns, input int a0, b0, c0, a1, b1, c1, a2, b2, c2);
        vec_t v;
        v.nh = 2'(nh); v.ns = 2'(ns);
        v.hs[0] = 8'(s0); v.hq[0] = 8'(q0); v.hl[0] = 8'(l0);
        v.hs[1] = 8'(s1); v.hq[1] = 8'(q1); v.hl[1] = 8'(l1);
        v.hs[2] = 8'(s2); v.hq[2] = 8'(q2); v.hl[2] = 8'(l2);
        v.es[0] = 8'(a0); v.eq[0] = 8'(b0); v.el[0] = 10'(c0);
        v.es[1] = 8'(a1); v.eq[1] = 8'(b1); v.el[1] = 10'(c1);
        v.es[2] = 8'(a2); v.eq[2] = 8'(b2); v.el[2] = 10'(c2);
        return v;
    endfunction

    function automatic logic kept(input logic [9:0] l);
`ifdef HIT_MIN_LEN_FILTER_EN
        return (l >= 10'd4);
`else
        return (l != 10'd0) || (l == 10'd0);
`endif
    endfunction

    task automatic push_hit(input logic [7:0] s, q, l);
        mem[wr_ptr] = {s, q, l};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_seg(input logic [7:0] s, q, input logic [9:0] l);
        if (kept(l)) exp_q.push_back({s, q, l});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_run++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
        end
    endtask

    // One clock: monitor at the falling edge, return just after the rising edge for driving.
    task automatic step();
        seg_t e;
        @(negedge clk);
        if (fifo_rd_en && fifo_empty) bad_rd++;
        if (flush_done) fd_cnt++;
        if (seg_valid && seg_ready) begin
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL seg_unexpected: got (%0d,%0d,%0d) required none", seg_s, seg_q, seg_l);
            end else begin
                e = exp_q.pop_front();
                if ({seg_s, seg_q, seg_l} !== e) begin
                    n_fail++;
                    $display("FAIL seg_data: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                             seg_s, seg_q, seg_l, e.s, e.q, e.l);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush_and_wait(input string nm);
        int fd0, c;
        fd0 = fd_cnt;
        c = 0;
        flush = 1'b1;
        while ((fd_cnt == fd0) && (c < 300)) begin
            step();
            c++;
        end
        chk(nm, fd_cnt - fd0, 1);
        flush = 1'b0;
        step();
        chk("sb_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < int'(v.nh); i++) push_hit(v.hs[i], v.hq[i], v.hl[i]);
        for (int i = 0; i < int'(v.ns); i++) expect_seg(v.es[i], v.eq[i], v.el[i]);
        flush_and_wait("vec_flush_done");
    endtask

    initial begin
        vecs[0]  = mkv(2, 10,4,3, 12,6,3, 0,0,0,       1, 10,4,5, 0,0,0, 0,0,0);
        vecs[1]  = mkv(2, 10,4,3, 20,5,2, 0,0,0,       2, 10,4,3, 20,5,2, 0,0,0);
        vecs[2]  = mkv(2, 0,0,4, 6,6,1, 0,0,0,         1, 0,0,7, 0,0,0, 0,0,0);
        vecs[3]  = mkv(2, 0,0,4, 7,7,1, 0,0,0,         2, 0,0,4, 7,7,1, 0,0,0);
        vecs[4]  = mkv(2, 5,1,0, 5,1,6, 0,0,0,         1, 5,1,6, 0,0,0, 0,0,0);
        vecs[5]  = mkv(2, 20,10,2, 15,5,3, 0,0,0,      2, 20,10,2, 15,5,3, 0,0,0);
        vecs[6]  = mkv(2, 30,30,10, 32,32,2, 0,0,0,    1, 30,30,10, 0,0,0, 0,0,0);
        vecs[7]  = mkv(1, 1,1,2, 0,0,0, 0,0,0,         1, 1,1,2, 0,0,0, 0,0,0);
        vecs[8]  = mkv(2, 50,40,3, 51,40,3, 0,0,0,     2, 50,40,3, 51,40,3, 0,0,0);
        vecs[9]  = mkv(2, 4,200,3, 5,201,3, 0,0,0,     1, 4,200,4, 0,0,0, 0,0,0);
        vecs[10] = mkv(3, 100,0,2, 103,3,2, 106,6,2,   1, 100,0,8, 0,0,0, 0,0,0);
        vecs[11] = mkv(3, 70,60,3, 0,0,0, 72,62,2,     1, 70,60,4, 0,0,0, 0,0,0);
        vecs[12] = mkv(3, 10,0,5, 9,0,5, 200,100,4,    3, 10,0,5, 9,0,5, 200,100,4);
        vecs[13] = mkv(2, 40,40,4, 44,44,4, 0,0,0,     1, 40,40,8, 0,0,0, 0,0,0);
        vecs[14] = mkv(2, 250,5,255, 255,10,255, 0,0,0, 1, 250,5,260, 0,0,0, 0,0,0);

        rst = 1'b0; flush = 1'b0; seg_ready = 1'b1;
        repeat (3) step();
        chk("reset_outputs", {fifo_rd_en, seg_valid, flush_done, busy, seg_s, seg_q, seg_l}, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // flush held high with nothing open: one pulse, re-armed only after flush drops
        begin
            int fd0;
            fd0 = fd_cnt;
            flush = 1'b1;
            repeat (10) step();
            chk("flush_once", fd_cnt - fd0, 1);
            flush = 1'b0;
            step();
            flush = 1'b1;
            repeat (5) step();
            chk("flush_rearm", fd_cnt - fd0, 2);
            flush = 1'b0;
            step();
            chk("idle_not_busy", busy, 0);
        end

        // stall in EMIT: outputs frozen, no reads, nothing lost afterwards
        seg_ready = 1'b0;
        push_hit(8'd10, 8'd4, 8'd4);
        push_hit(8'd20, 8'd5, 8'd4);
        push_hit(8'd40, 8'd40, 8'd5);
        expect_seg(8'd10, 8'd4, 10'd4);
        expect_seg(8'd20, 8'd5, 10'd4);
        expect_seg(8'd40, 8'd40, 10'd5);
        repeat (5) step();
        chk("emit_latency_early", seg_valid, 0);
        step();
        chk("emit_latency", seg_valid, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("emit_hold", {seg_valid, fifo_rd_en, seg_s, seg_q, seg_l},
                {1'b1, 1'b0, 8'd10, 8'd4, 10'd4});
        end
        seg_ready = 1'b1;
        flush_and_wait("stall_flush_done");

        // bubble between hits, then reset while stalled in EMIT
        seg_ready = 1'b0;
        push_hit(8'd50, 8'd50, 8'd4);
        push_hit(8'd5, 8'd1, 8'd0);
        push_hit(8'd60, 8'd70, 8'd4);
        repeat (9) step();
        chk("bubble_emit", {fifo_empty, seg_valid, seg_s, seg_q, seg_l},
            {1'b1, 1'b1, 8'd50, 8'd50, 10'd4});
        rst = 1'b0;
        step();
        chk("mid_emit_reset", {fifo_rd_en, seg_valid, flush_done, busy, seg_s, seg_q, seg_l}, 0);
        rst = 1'b1;
        seg_ready = 1'b1;
        step();
        flush_and_wait("post_reset_flush_done");

        chk("no_read_when_empty", bad_rd, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
